// File: rtl/phy_tx_striper_if.sv
// Link-to-PHY transmit bus: word handshake in, two striped byte lanes out.
interface phy_tx_striper_if;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  data_out_0;
    logic [7:0]  data_out_1;
    logic        valid_out_0;
    logic        valid_out_1;

    modport master (
        output data_in, valid_in,
        input  ready_out, data_out_0, data_out_1, valid_out_0, valid_out_1
    );

    modport slave (
        input  data_in, valid_in,
        output ready_out, data_out_0, data_out_1, valid_out_0, valid_out_1
    );
endinterface

// File: rtl/phy_tx_striper.sv
// PHY transmit striper: 2-entry word FIFO feeding two byte lanes, 2 cycles per word.
// Optional skip-symbol insertion is enabled with the PHY_TX_SKIP_EN macro.
module phy_tx_striper #(
    parameter logic [7:0] IDLE_SYM     = 8'hBC,
    parameter logic [7:0] SKP_SYM      = 8'h1C,
    parameter int         SKP_INTERVAL = 16
) (
    input  logic              clk_32f,
    input  logic              reset,
    phy_tx_striper_if.slave   bus
);

`ifdef PHY_TX_SKIP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO, ST_SKIP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO} state_t;
`endif

    state_t      r_state;
    logic [31:0] r_mem [2];
    logic        r_wrPtr;
    logic        r_rdPtr;
    logic [1:0]  r_count;
    logic        r_ready;
    logic [7:0]  r_data0;
    logic [7:0]  r_data1;
    logic        r_valid;

    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_countNext;
    logic [31:0] w_head;
    logic        w_skipNow;

    // ready comes from registered occupancy, so a full FIFO refuses even on a pop cycle
    assign w_push = bus.valid_in & r_ready;
    assign w_pop  = (r_state == ST_HI);
    assign w_head = r_mem[r_rdPtr];

    always_comb begin
        w_countNext = r_count;
        if (w_push && !w_pop)
            w_countNext = r_count + 2'd1;
        else if (!w_push && w_pop)
            w_countNext = r_count - 2'd1;
    end

    always_ff @(posedge clk_32f) begin
        if (w_push)
            r_mem[r_wrPtr] <= bus.data_in;
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
            r_ready <= 1'b0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)
                r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= w_countNext;
            r_ready <= (w_countNext != 2'd2);
        end
    end

`ifdef PHY_TX_SKIP_EN
    localparam int CW = $clog2(SKP_INTERVAL);
    localparam logic [CW-1:0] CNT_MAX = CW'(SKP_INTERVAL - 1);

    logic [CW-1:0] r_skpCnt;
    logic          r_skpPend;

    assign w_skipNow = r_skpPend;

    // Free-running interval counter; cleared on the edge that enters the SKIP cycle
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_skpCnt  <= '0;
            r_skpPend <= 1'b0;
        end else if (r_skpPend && (r_state != ST_HI)) begin
            r_skpCnt  <= '0;
            r_skpPend <= 1'b0;
        end else if (r_skpCnt != CNT_MAX) begin
            r_skpCnt <= r_skpCnt + 1'b1;
            if (r_skpCnt == CNT_MAX - 1'b1)
                r_skpPend <= 1'b1;
        end
    end
`else
    logic w_unusedCfg;

    assign w_skipNow   = 1'b0;
    assign w_unusedCfg = ^{SKP_SYM, SKP_INTERVAL};
`endif

    // HI always finishes the current word; every other state is a word boundary
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_data0 <= IDLE_SYM;
            r_data1 <= IDLE_SYM;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_HI: begin
                    r_data0 <= w_head[23:16];
                    r_data1 <= w_head[31:24];
                    r_valid <= 1'b1;
                    r_state <= ST_LO;
                end
                default: begin
`ifdef PHY_TX_SKIP_EN
                    if (w_skipNow) begin
                        r_data0 <= SKP_SYM;
                        r_data1 <= SKP_SYM;
                        r_valid <= 1'b0;
                        r_state <= ST_SKIP;
                    end else
`endif
                    if (r_count != 2'd0) begin
                        r_data0 <= w_head[7:0];
                        r_data1 <= w_head[15:8];
                        r_valid <= 1'b1;
                        r_state <= ST_HI;
                    end else begin
                        r_data0 <= IDLE_SYM;
                        r_data1 <= IDLE_SYM;
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ready_out   = r_ready;
    assign bus.data_out_0  = r_data0;
    assign bus.data_out_1  = r_data1;
    assign bus.valid_out_0 = r_valid;
    assign bus.valid_out_1 = r_valid;

endmodule
